// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared types and helpers for the edge detector array
package edge_detect_pkg;

    localparam int MAX_SYNC_STAGES = 3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_t;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        RISE = 2'b01,
        ONE  = 2'b10,
        FALL = 2'b11
    } edge_state_t;

    function automatic logic rise_enabled(input edge_mode_t m);
        return (m == EDGE_RISE) || (m == EDGE_BOTH);
    endfunction

    function automatic logic fall_enabled(input edge_mode_t m);
        return (m == EDGE_FALL) || (m == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/edge_detect_channel.sv
// rtl/edge_detect_channel.sv - one channel: synchroniser, edge FSM, tick qualification, sticky pending
module edge_detect_channel
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit MOORE       = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level,
    input  logic [1:0] mode,
    input  logic       clr_pending,
    output logic       tick,
    output logic       pending
);

    localparam int STAGES = (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES : SYNC_STAGES;

    logic        ls;
    logic        rise;
    logic        fall;
    edge_state_t state;
    edge_mode_t  edge_mode;

    generate
        if (STAGES == 0) begin : g_nosync
            assign ls = level;
        end else begin : g_sync
            logic [STAGES-1:0] s;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s <= '0;
                end else begin
                    s[0] <= level;
                    for (int i = 1; i < STAGES; i++) begin
                        s[i] <= s[i-1];
                    end
                end
            end
            assign ls = s[STAGES-1];
        end
    endgenerate

    // State follows ls independent of mode, so changing mode can never fabricate an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ZERO;
        end else if (MOORE) begin
            case (state)
                ZERO:    if (ls) state <= RISE;
                RISE:    state <= ls ? ONE : FALL;
                ONE:     if (!ls) state <= FALL;
                FALL:    state <= ls ? RISE : ZERO;
                default: state <= ZERO;
            endcase
        end else begin
            state <= ls ? ONE : ZERO;
        end
    end

    assign rise = MOORE ? (state == RISE) : ((state == ZERO) && ls);
    assign fall = MOORE ? (state == FALL) : ((state == ONE) && !ls);

    assign edge_mode = edge_mode_t'(mode);

    // Gated by reset so an unsynchronised level cannot leak a tick while held in reset.
    assign tick = !reset && ((rise && rise_enabled(edge_mode)) || (fall && fall_enabled(edge_mode)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (tick) begin
            pending <= 1'b1;
        end else if (clr_pending) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_detect_array.sv
// rtl/edge_detect_array.sv - N-channel edge detector with sticky per-channel event flags
module edge_detect_array
    import edge_detect_pkg::*;
#(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit MOORE       = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] level,
    input  logic [1:0]   mode,
    input  logic [N-1:0] clr_pending,
    output logic [N-1:0] tick,
    output logic [N-1:0] pending,
    output logic         any_pending
);

    generate
        for (genvar ch = 0; ch < N; ch++) begin : g_ch
            edge_detect_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .MOORE       (MOORE)
            ) u_channel (
                .clk         (clk),
                .reset       (reset),
                .level       (level[ch]),
                .mode        (mode),
                .clr_pending (clr_pending[ch]),
                .tick        (tick[ch]),
                .pending     (pending[ch])
            );
        end
    endgenerate

    assign any_pending = |pending;

endmodule

// File: doc/edge_detect_array.md
# edge_detect_array

Parametrised, multi-channel successor to the single-input Mealy rising-edge detector. Each of `N` channels synchronises an asynchronous level input, detects rising, falling or both edges according to a runtime mode, and emits a one-cycle `tick` in either Mealy or Moore timing. Each channel also holds a sticky `pending` flag until software or a consumer clears it. The block sits between raw button/switch/status inputs and the FSMs or interrupt logic that consume single-cycle events.

## Interface
- `N`, 4: number of independent channels (1..32).
- `SYNC_STAGES`, 2: synchroniser depth per channel (0..3). A value of 0 means `level` is used directly.
- `MOORE`, 0: tick timing. 0 selects Mealy (tick in the same cycle the synchronised level changes); 1 selects Moore (tick registered, one cycle later).

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `level`  in  N  raw level inputs, one per channel.
- `mode`  in  2  edge select, shared by all channels: 00 rising, 01 falling, 10 both, 11 none (ticks suppressed).
- `clr_pending`  in  N  per-channel clear of the `pending` flag, sampled on `clk`.
- `tick`  out  N  one-cycle edge pulse per channel.
- `pending`  out  N  sticky per-channel event flag.
- `any_pending`  out  1  OR-reduction of `pending`.

## Operation
- Synchroniser: `s[0] <= level`, then `s[i] <= s[i-1]`. Synchronised level `ls = s[SYNC_STAGES-1]`, or `level` when `SYNC_STAGES` = 0.
- Per-channel FSM states:
  - Mealy: ZERO, ONE.
  - Moore: ZERO, RISE, ONE, FALL.
- Mealy transitions (per channel):
  - ZERO & ls=1 -> ONE, raw rise = 1 combinationally.
  - ONE & ls=0 -> ZERO, raw fall = 1 combinationally.
  - Otherwise the state holds.
- Moore transitions (per channel):
  - ZERO & ls=1 -> RISE.
  - RISE & ls=1 -> ONE; RISE & ls=0 -> FALL.
  - ONE & ls=0 -> FALL.
  - FALL & ls=0 -> ZERO; FALL & ls=1 -> RISE.
  - In Moore, rise = (state==RISE) and fall = (state==FALL).
- Tick qualification: `tick = (rise & mode∈{00,10}) | (fall & mode∈{01,10})`. Mode 11 gives tick = 0.
- State tracks `ls` regardless of `mode`, so a mode change never produces a spurious tick.
- `pending` update, evaluated per clock:
  - tick=1 sets it.
  - Otherwise `clr_pending`=1 clears it.
  - Otherwise it holds.
  - When tick and clear occur in the same cycle, set wins.

## Timing
- Reset values: all sync flops 0, all states ZERO, `tick`=0, `pending`=0, `any_pending`=0.
- A level held high across reset release is reported as a rising edge once it reaches `ls`.
- Latency is counted from the first `clk` edge that samples the new `level`:
  - Mealy: tick is high in the cycle after `SYNC_STAGES`-1 further edges. With `SYNC_STAGES`=0, tick is combinational from `level` in the current cycle.
  - Moore: one cycle later than Mealy; tick is glitch-free and registered.
- Tick width:
  - Exactly one cycle per qualifying `ls` transition.
  - A level pulse lasting 1 cycle at `ls` produces a rise tick and a fall tick on consecutive cycles in mode 10.
- `pending` rises on the clock edge that ends the tick cycle. `any_pending` is combinational from `pending`.
- A reset asserted mid-sequence clears everything within the same cycle; no tick appears while `reset`=1.

## Structure
- Package `edge_detect_pkg`:
  - `edge_mode_t` enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE).
  - `edge_state_t` enum (ZERO, RISE, ONE, FALL).
  - Constant `MAX_SYNC_STAGES`=3.
- Sub-module `edge_detect_channel`: synchroniser, FSM, tick qualification and pending flag for one channel.
- The top level instantiates `N` channels in a generate loop and OR-reduces `pending` into `any_pending`.

## Test plan
- Reset release with `level`=0001, Mealy, S=2, mode 00 -> `tick[0]`=1 for one cycle at the 2nd edge after release; `pending`=0001; `any_pending`=1.
- Channel 1 receives a 0->1->0 pulse 5 cycles wide, mode 10:
  - Mealy: ticks 2 cycles after the rising sample and again 5 cycles later.
  - Moore: each tick arrives one cycle later.
  - No other bit of `tick` toggles.
- Mode 01 with a rising then falling edge on channel 2 -> only the fall tick appears. Switching mode to 11 mid-high, then dropping `level`, gives no tick.
- Tick and `clr_pending[3]` asserted in the same cycle -> `pending[3]` stays 1. A clear in the following cycle with no tick -> `pending[3]`=0 after that edge.
- `reset` asserted for 1 cycle while channel 0 is in RISE (Moore) -> `tick`=0 immediately, `pending`=0. Level still high at release -> a fresh rise tick appears after S+1 cycles.
- S=0, Mealy: `level[0]` toggles between clock edges -> `tick[0]` follows combinationally within the same cycle, matching single-bit legacy behaviour.
